tree_adder_sequencer: RTL and testbench

TREE_ADDER_SEQUENCER -- requirements
Module: tree_adder_sequencer

---
 rtl/tree_adder_pkg.sv | 20 ++
 rtl/shared_adder10.sv | 15 +
 rtl/tree_adder_sequencer.sv | 132 +++++++++++++
 tb/tb_tree_adder_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/tree_adder_pkg.sv
// Shared definitions for the tree adder sequencer: operand/result widths and
// the FSM state encoding. Imported by the top and the shared adder.
package tree_adder_pkg;

   localparam int unsigned A_W    = 4;   // width of leaf operands a, b
   localparam int unsigned C_W    = 8;   // width of leaf operands c, d
   localparam int unsigned SUM1_W = 5;   // a + b, carry kept
   localparam int unsigned SUM2_W = 9;   // c + d, carry kept
   localparam int unsigned SUM3_W = 10;  // sum1 + sum2, carry kept
   localparam int unsigned ADD_W  = 10;  // shared adder datapath width

   typedef enum logic [2:0] {
      StIdle,
      StAddAb,
      StAddCd,
      StAddTree,
      StDone
   } state_e;

endpackage

// File: rtl/shared_adder10.sv
// Combinational 10-bit adder time-shared by all three tree additions.
// Ports:
//   op_a_i, op_b_i : addends (callers zero-extend narrower operands)
//   sum_o          : op_a_i + op_b_i; every operand pair used stays below 2^10
module shared_adder10
   import tree_adder_pkg::*;
(
   input  logic [ADD_W-1:0] op_a_i,
   input  logic [ADD_W-1:0] op_b_i,
   output logic [ADD_W-1:0] sum_o
);

   assign sum_o = op_a_i + op_b_i;

endmodule

// File: rtl/tree_adder_sequencer.sv
// Sequenced adder tree: computes sum1=a+b, sum2=c+d, sum3=sum1+sum2 on a single
// shared adder, one addition per cycle, then holds the result until consumed.
// Ports:
//   clk, rst            : clock and asynchronous active-high reset
//   in_valid / in_ready : operand handshake (ready only while idle)
//   a, b, c, d          : tree leaf operands, captured on acceptance
//   out_valid/out_ready : result handshake (valid only in the done state)
//   sum1, sum2, sum3    : registered partial and final sums
//   busy                : high whenever a job is in flight or awaiting consumption
//   done_count          : number of consumed results, wrapping
module tree_adder_sequencer
   import tree_adder_pkg::*;
#(
   parameter int unsigned COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [A_W-1:0]     a,
   input  logic [A_W-1:0]     b,
   input  logic [C_W-1:0]     c,
   input  logic [C_W-1:0]     d,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SUM1_W-1:0]  sum1,
   output logic [SUM2_W-1:0]  sum2,
   output logic [SUM3_W-1:0]  sum3,
   output logic               busy,
   output logic [COUNT_W-1:0] done_count
);

   state_e              state_q, state_d;
   logic [A_W-1:0]      a_q, a_d, b_q, b_d;
   logic [C_W-1:0]      c_q, c_d, d_q, d_d;
   logic [SUM1_W-1:0]   sum1_q, sum1_d;
   logic [SUM2_W-1:0]   sum2_q, sum2_d;
   logic [SUM3_W-1:0]   sum3_q, sum3_d;
   logic [COUNT_W-1:0]  cnt_q, cnt_d;
   logic [ADD_W-1:0]    op_a, op_b, add_res;

   shared_adder10 u_adder (
      .op_a_i (op_a),
      .op_b_i (op_b),
      .sum_o  (add_res)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      d_d     = d_q;
      sum1_d  = sum1_q;
      sum2_d  = sum2_q;
      sum3_d  = sum3_q;
      cnt_d   = cnt_q;
      op_a    = '0;
      op_b    = '0;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               c_d     = c;
               d_d     = d;
               state_d = StAddAb;
            end
         end
         StAddAb: begin
            op_a    = {{(ADD_W - A_W){1'b0}}, a_q};
            op_b    = {{(ADD_W - A_W){1'b0}}, b_q};
            sum1_d  = add_res[SUM1_W-1:0];
            state_d = StAddCd;
         end
         StAddCd: begin
            op_a    = {{(ADD_W - C_W){1'b0}}, c_q};
            op_b    = {{(ADD_W - C_W){1'b0}}, d_q};
            sum2_d  = add_res[SUM2_W-1:0];
            state_d = StAddTree;
         end
         StAddTree: begin
            op_a    = {{(ADD_W - SUM1_W){1'b0}}, sum1_q};
            op_b    = {{(ADD_W - SUM2_W){1'b0}}, sum2_q};
            sum3_d  = add_res[SUM3_W-1:0];
            state_d = StDone;
         end
         StDone: begin
            // in_valid is not looked at here, so a request coinciding with the
            // handshake waits for the following idle cycle.
            if (out_ready) begin
               cnt_d   = cnt_q + COUNT_W'(1);
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         sum1_q  <= '0;
         sum2_q  <= '0;
         sum3_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         d_q     <= d_d;
         sum1_q  <= sum1_d;
         sum2_q  <= sum2_d;
         sum3_q  <= sum3_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready   = (state_q == StIdle);
   assign out_valid  = (state_q == StDone);
   assign busy       = (state_q != StIdle);
   assign sum1       = sum1_q;
   assign sum2       = sum2_q;
   assign sum3       = sum3_q;
   assign done_count = cnt_q;

endmodule

// File: tb/tb_tree_adder_sequencer.sv
// Randomized self-checking bench for tree_adder_sequencer. Two instances share
// all inputs: the default 16-bit counter and a 2-bit counter for wrap checks.
module tb_tree_adder_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, out_ready;
   logic [3:0]  a, b;
   logic [7:0]  c, d;

   logic        in_ready, out_valid, busy;
   logic [4:0]  sum1;
   logic [8:0]  sum2;
   logic [9:0]  sum3;
   logic [15:0] done_count;

   logic        w_in_ready, w_out_valid, w_busy;
   logic [4:0]  w_sum1;
   logic [8:0]  w_sum2;
   logic [9:0]  w_sum3;
   logic [1:0]  w_done_count;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: number of consumed results and last completed sums.
   int          exp_cnt;
   logic [4:0]  e1;
   logic [8:0]  e2;
   logic [9:0]  e3;

   always #5 clk = ~clk;

   tree_adder_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .c          (c),
      .d          (d),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .sum1       (sum1),
      .sum2       (sum2),
      .sum3       (sum3),
      .busy       (busy),
      .done_count (done_count)
   );

   tree_adder_sequencer #(.COUNT_W(2)) dut_w (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (w_in_ready),
      .a          (a),
      .b          (b),
      .c          (c),
      .d          (d),
      .out_valid  (w_out_valid),
      .out_ready  (out_ready),
      .sum1       (w_sum1),
      .sum2       (w_sum2),
      .sum3       (w_sum3),
      .busy       (w_busy),
      .done_count (w_done_count)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic scramble();
      a = 4'($urandom);
      b = 4'($urandom);
      c = 8'($urandom);
      d = 8'($urandom);
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_in_ready"},  32'(in_ready), 1);
      check_eq({tag, "_out_valid"}, 32'(out_valid), 0);
      check_eq({tag, "_busy"},      32'(busy), 0);
      check_eq({tag, "_sum1"},      32'(sum1), 32'(e1));
      check_eq({tag, "_sum2"},      32'(sum2), 32'(e2));
      check_eq({tag, "_sum3"},      32'(sum3), 32'(e3));
      check_eq({tag, "_cnt16"},     32'(done_count), 32'(exp_cnt % 65536));
      check_eq({tag, "_cnt2"},      32'(w_done_count), 32'(exp_cnt % 4));
      check_eq({tag, "_w_busy"},    32'(w_busy), 0);
      check_eq({tag, "_w_sum3"},    32'(w_sum3), 32'(e3));
   endtask

   // Called at a negedge while idle. Presents one job, scrambles inputs while it
   // is in flight, holds DONE for 'stall' cycles with out_ready low, then
   // consumes it with in_valid also high during the handshake.
   task automatic run_job(input logic [3:0] ja, input logic [3:0] jb,
                          input logic [7:0] jc, input logic [7:0] jd, input int stall);
      logic [4:0] n1;
      logic [8:0] n2;
      logic [9:0] n3;
      int waited;
      n1 = 5'(ja) + 5'(jb);
      n2 = 9'(jc) + 9'(jd);
      n3 = 10'(n1) + 10'(n2);
      waited = 0;
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check_eq("accept_ready", 32'(in_ready), 1);
      a = ja;
      b = jb;
      c = jc;
      d = jd;
      in_valid  = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      for (int j = 1; j <= 4; j++) begin
         @(negedge clk);
         check_eq("job_busy",      32'(busy), 1);
         check_eq("job_in_ready",  32'(in_ready), 0);
         check_eq("job_out_valid", 32'(out_valid), 32'(j == 4));
         check_eq("job_sum1",      32'(sum1), (j >= 2) ? 32'(n1) : 32'(e1));
         check_eq("job_sum2",      32'(sum2), (j >= 3) ? 32'(n2) : 32'(e2));
         check_eq("job_sum3",      32'(sum3), (j >= 4) ? 32'(n3) : 32'(e3));
         scramble();
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         if (j == 4) begin
            out_ready = (stall == 0);
            if (stall == 0) in_valid = 1'b1;
         end
      end
      for (int i = 1; i <= stall; i++) begin
         @(negedge clk);
         check_eq("stall_out_valid", 32'(out_valid), 1);
         check_eq("stall_in_ready",  32'(in_ready), 0);
         check_eq("stall_sum1",      32'(sum1), 32'(n1));
         check_eq("stall_sum2",      32'(sum2), 32'(n2));
         check_eq("stall_sum3",      32'(sum3), 32'(n3));
         scramble();
         out_ready = (i == stall);
         in_valid  = (i == stall) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      exp_cnt++;
      e1 = n1;
      e2 = n2;
      e3 = n3;
      check_idle("handshake");
      in_valid  = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
   endtask

   // Reset while the job sits in the c+d step; the job must vanish.
   task automatic reset_mid_job();
      scramble();
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("pre_rst_busy", 32'(busy), 1);
      rst = 1'b1;
      #1;
      exp_cnt = 0;
      e1 = '0;
      e2 = '0;
      e3 = '0;
      check_idle("mid_rst");
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_idle("rst_release");
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check_idle("after_rst");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      c = '0;
      d = '0;
      exp_cnt = 0;
      e1 = '0;
      e2 = '0;
      e3 = '0;
      repeat (2) @(negedge clk);
      check_eq("rst_in_ready", 32'(in_ready), 1);
      check_eq("rst_sum3",     32'(sum3), 0);
      rst = 1'b0;
      @(negedge clk);
      check_idle("post_rst");

      run_job(4'd3, 4'd4, 8'd10, 8'd20, 0);
      run_job(4'd15, 4'd15, 8'd255, 8'd255, 0);
      run_job(4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 6);
      run_job(4'd1, 4'd1, 8'd1, 8'd1, 0);
      run_job(4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 1);
      reset_mid_job();
      repeat (20) begin
         run_job(4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
                 int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
